// File: rtl/mmu_seg_dlx_if.sv
//==============================================================================
// Module      : mmu_seg_dlx_if
// Description : Request/response bus between the DLX address path and the MMU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mmu_seg_dlx_if #(
    parameter int VA_W = 32,
    parameter int PA_W = 24
);
    logic            req_valid;
    logic            req_ready;
    logic [VA_W-1:0] req_addr;
    logic            req_write;
    logic            resp_valid;
    logic            resp_ready;
    logic [PA_W-1:0] resp_paddr;
    logic            resp_fault;
    logic [1:0]      resp_cause;

    modport master (
        output req_valid, req_addr, req_write, resp_ready,
        input  req_ready, resp_valid, resp_paddr, resp_fault, resp_cause
    );

    modport slave (
        input  req_valid, req_addr, req_write, resp_ready,
        output req_ready, resp_valid, resp_paddr, resp_fault, resp_cause
    );
endinterface

`default_nettype wire

// File: rtl/mmu_seg_dlx.sv
//==============================================================================
// Module      : mmu_seg_dlx
// Description : Segment MMU (base/limit/protection) with one-deep registered
//               valid/ready output stage and fault logging.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mmu_seg_dlx #(
    parameter int VA_W   = 32,
    parameter int PA_W   = 24,
    parameter int NSEG   = 4,
    parameter int FCNT_W = 8,
    localparam int SEL_W = $clog2(NSEG)
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    mmu_seg_dlx_if.slave               bus,
    input  wire logic                  cfg_we_i,
    input  wire logic [SEL_W-1:0]      cfg_idx_i,
    input  wire logic [PA_W-1:0]       cfg_base_i,
    input  wire logic [VA_W-SEL_W-1:0] cfg_limit_i,
    input  wire logic                  cfg_en_i,
    input  wire logic                  cfg_ro_i,
    input  wire logic                  mode_we_i,
    input  wire logic                  mode_i,
    output logic      [FCNT_W-1:0]     fault_cnt_o,
    output logic      [VA_W-1:0]       fault_va_o
);

    localparam int         OFF_W          = VA_W - SEL_W;
    localparam logic [1:0] C_CAUSE_NONE   = 2'b00;
    localparam logic [1:0] C_CAUSE_DIS    = 2'b01;
    localparam logic [1:0] C_CAUSE_LIMIT  = 2'b10;
    localparam logic [1:0] C_CAUSE_RO     = 2'b11;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PA_W-1:0]   base_q  [NSEG];
    logic [OFF_W-1:0]  limit_q [NSEG];
    logic [NSEG-1:0]   en_q;
    logic [NSEG-1:0]   ro_q;
    logic              mode_q;

    logic [PA_W-1:0]   paddr_q;
    logic              fault_q;
    logic [1:0]        cause_q;
    logic [FCNT_W-1:0] fault_cnt_q;
    logic [VA_W-1:0]   fault_va_q;

    logic [SEL_W-1:0]  w_seg;
    logic [OFF_W-1:0]  w_off;
    logic [PA_W-1:0]   w_sum;
    logic [PA_W-1:0]   w_paddr;
    logic              w_fault;
    logic [1:0]        w_cause;
    logic              w_req_ready;
    logic              w_accept;

    assign w_seg = bus.req_addr[VA_W-1 -: SEL_W];
    assign w_off = bus.req_addr[OFF_W-1:0];
    // Sum is kept at PA_W bits so the carry out of base+offset is dropped.
    assign w_sum = base_q[w_seg] + PA_W'(w_off);

    always_comb begin
        w_paddr = bus.req_addr[PA_W-1:0];
        w_fault = 1'b0;
        w_cause = C_CAUSE_NONE;
        if (mode_q) begin
            w_paddr = '0;
            if (!en_q[w_seg]) begin
                w_fault = 1'b1;
                w_cause = C_CAUSE_DIS;
            end else if (w_off > limit_q[w_seg]) begin
                w_fault = 1'b1;
                w_cause = C_CAUSE_LIMIT;
            end else if (bus.req_write && ro_q[w_seg]) begin
                w_fault = 1'b1;
                w_cause = C_CAUSE_RO;
            end else begin
                w_paddr = w_sum;
            end
        end
    end

    assign w_req_ready = (state_q == S_EMPTY) || bus.resp_ready;
    assign w_accept    = bus.req_valid && w_req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (w_accept) state_d = S_FULL;
            S_FULL:  if (bus.resp_ready && !bus.req_valid) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            paddr_q     <= '0;
            fault_q     <= 1'b0;
            cause_q     <= C_CAUSE_NONE;
            fault_cnt_q <= '0;
            fault_va_q  <= '0;
        end else if (w_accept) begin
            paddr_q <= w_paddr;
            fault_q <= w_fault;
            cause_q <= w_cause;
            if (w_fault) begin
                fault_va_q <= bus.req_addr;
                if (fault_cnt_q != {FCNT_W{1'b1}}) begin
                    fault_cnt_q <= fault_cnt_q + FCNT_W'(1);
                end
            end
        end
    end

    // Table and mode update at the edge, so a same-cycle accept sees old values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NSEG; i++) begin
                base_q[i]  <= '0;
                limit_q[i] <= '0;
            end
            en_q   <= '0;
            ro_q   <= '0;
            mode_q <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                base_q[cfg_idx_i]  <= cfg_base_i;
                limit_q[cfg_idx_i] <= cfg_limit_i;
                en_q[cfg_idx_i]    <= cfg_en_i;
                ro_q[cfg_idx_i]    <= cfg_ro_i;
            end
            if (mode_we_i) begin
                mode_q <= mode_i;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (state_q == S_FULL);
    assign bus.resp_paddr = paddr_q;
    assign bus.resp_fault = fault_q;
    assign bus.resp_cause = cause_q;
    assign fault_cnt_o    = fault_cnt_q;
    assign fault_va_o     = fault_va_q;

endmodule

`default_nettype wire

// File: tb/tb_mmu_seg_dlx.sv
//==============================================================================
// Module      : tb_mmu_seg_dlx
// Description : Self-checking bench for mmu_seg_dlx against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mmu_seg_dlx;

    localparam int VA_W   = 32;
    localparam int PA_W   = 24;
    localparam int NSEG   = 4;
    localparam int FCNT_W = 8;
    localparam int SEL_W  = 2;
    localparam int OFF_W  = VA_W - SEL_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [SEL_W-1:0]  cfg_idx = '0;
    logic [PA_W-1:0]   cfg_base = '0;
    logic [OFF_W-1:0]  cfg_limit = '0;
    logic              cfg_en = 1'b0;
    logic              cfg_ro = 1'b0;
    logic              mode_we = 1'b0;
    logic              mode_in = 1'b0;
    logic [FCNT_W-1:0] fault_cnt;
    logic [VA_W-1:0]   fault_va;

    int n_checks = 0;
    int n_pass   = 0;

    mmu_seg_dlx_if #(.VA_W(VA_W), .PA_W(PA_W)) bus ();

    mmu_seg_dlx #(.VA_W(VA_W), .PA_W(PA_W), .NSEG(NSEG), .FCNT_W(FCNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .cfg_we_i    (cfg_we),
        .cfg_idx_i   (cfg_idx),
        .cfg_base_i  (cfg_base),
        .cfg_limit_i (cfg_limit),
        .cfg_en_i    (cfg_en),
        .cfg_ro_i    (cfg_ro),
        .mode_we_i   (mode_we),
        .mode_i      (mode_in),
        .fault_cnt_o (fault_cnt),
        .fault_va_o  (fault_va)
    );

    always #5 clk = ~clk;

    // Reference model: segment table, mode and fault log as plain values.
    longint unsigned m_base  [NSEG];
    longint unsigned m_limit [NSEG];
    bit              m_en    [NSEG];
    bit              m_ro    [NSEG];
    bit              m_mode;
    int unsigned     m_fcnt;
    logic [VA_W-1:0] m_fva;

    logic [PA_W-1:0] e_paddr;
    logic            e_fault;
    logic [1:0]      e_cause;

    function automatic void model_reset();
        for (int i = 0; i < NSEG; i++) begin
            m_base[i] = 0; m_limit[i] = 0; m_en[i] = 0; m_ro[i] = 0;
        end
        m_mode = 0; m_fcnt = 0; m_fva = '0;
    endfunction

    function automatic void model_accept(input logic [VA_W-1:0] a, input bit wr);
        longint unsigned av  = a;
        longint unsigned seg = av / (64'd1 << OFF_W);
        longint unsigned off = av % (64'd1 << OFF_W);
        e_fault = 1'b0; e_cause = 2'd0; e_paddr = '0;
        if (!m_mode)                          e_paddr = PA_W'(av % (64'd1 << PA_W));
        else if (!m_en[seg])                  begin e_fault = 1'b1; e_cause = 2'd1; end
        else if (off > m_limit[seg])          begin e_fault = 1'b1; e_cause = 2'd2; end
        else if (wr && m_ro[seg])             begin e_fault = 1'b1; e_cause = 2'd3; end
        else e_paddr = PA_W'((m_base[seg] + off) % (64'd1 << PA_W));
        if (e_fault) begin
            if (m_fcnt < 255) m_fcnt = m_fcnt + 1;
            m_fva = a;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0;
        bus.resp_ready = 1'b1; cfg_we = 1'b0; mode_we = 1'b0;
    endtask

    task automatic drain();
        idle();
        tick();
    endtask

    task automatic do_cfg(input int idx, input logic [PA_W-1:0] base,
                          input logic [OFF_W-1:0] lim, input bit en, input bit ro);
        cfg_we = 1'b1; cfg_idx = SEL_W'(idx); cfg_base = base;
        cfg_limit = lim; cfg_en = en; cfg_ro = ro;
        tick();
        cfg_we = 1'b0;
        m_base[idx] = base; m_limit[idx] = lim; m_en[idx] = en; m_ro[idx] = ro;
    endtask

    task automatic do_mode(input bit m);
        mode_we = 1'b1; mode_in = m;
        tick();
        mode_we = 1'b0;
        m_mode = m;
    endtask

    task automatic send(input logic [VA_W-1:0] a, input bit wr);
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_write = wr; bus.resp_ready = 1'b1;
        model_accept(a, wr);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({bus.resp_valid, bus.resp_fault, bus.resp_cause} !== 4'b0)
            $display("FAIL reset_resp: valid/fault/cause=%b expected 0000",
                     {bus.resp_valid, bus.resp_fault, bus.resp_cause});
        else n_pass++;
        n_checks++;
        if (bus.resp_paddr !== '0 || fault_cnt !== '0 || fault_va !== '0)
            $display("FAIL reset_regs: paddr=%h cnt=%0d va=%h expected 0", bus.resp_paddr, fault_cnt, fault_va);
        else n_pass++;
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
        else n_pass++;
    endtask

    task automatic test_bypass();
        send(32'hAB12_3456, 1'b0);
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_paddr !== 24'h123456 || bus.resp_fault !== 1'b0)
            $display("FAIL bypass_rd: v=%b pa=%h f=%b expected 1/123456/0", bus.resp_valid, bus.resp_paddr, bus.resp_fault);
        else n_pass++;
        send(32'hFFFF_FFFF, 1'b1);
        n_checks++;
        if (bus.resp_paddr !== 24'hFFFFFF || bus.resp_fault !== 1'b0)
            $display("FAIL bypass_wr: pa=%h f=%b expected ffffff/0", bus.resp_paddr, bus.resp_fault);
        else n_pass++;
    endtask

    task automatic test_translate();
        do_cfg(0, 24'h100000, 30'h0000FFFF, 1'b1, 1'b0);
        do_mode(1'b1);
        send(32'h0000_0010, 1'b0);
        n_checks++;
        if (bus.resp_paddr !== 24'h100010 || bus.resp_fault !== 1'b0)
            $display("FAIL xlate_basic: pa=%h f=%b expected 100010/0", bus.resp_paddr, bus.resp_fault);
        else n_pass++;
        send(32'h0000_FFFF, 1'b1);
        n_checks++;
        if (bus.resp_paddr !== 24'h10FFFF || bus.resp_fault !== 1'b0)
            $display("FAIL xlate_at_limit: pa=%h f=%b expected 10ffff/0", bus.resp_paddr, bus.resp_fault);
        else n_pass++;
        send(32'h0001_0000, 1'b0);
        n_checks++;
        if (bus.resp_fault !== 1'b1 || bus.resp_cause !== 2'b10 || bus.resp_paddr !== '0)
            $display("FAIL xlate_over_limit: f=%b c=%b pa=%h expected 1/10/0", bus.resp_fault, bus.resp_cause, bus.resp_paddr);
        else n_pass++;
        n_checks++;
        if (fault_cnt !== 8'd1 || fault_va !== 32'h0001_0000)
            $display("FAIL fault_log: cnt=%0d va=%h expected 1/00010000", fault_cnt, fault_va);
        else n_pass++;
    endtask

    task automatic test_protection();
        do_cfg(1, 24'h200000, '1, 1'b1, 1'b1);
        do_cfg(2, 24'h300000, '1, 1'b0, 1'b0);
        do_cfg(3, 24'h000000, '0, 1'b0, 1'b1);
        send(32'h4000_0000, 1'b1);
        n_checks++;
        if (bus.resp_fault !== 1'b1 || bus.resp_cause !== 2'b11)
            $display("FAIL ro_write: f=%b c=%b expected 1/11", bus.resp_fault, bus.resp_cause);
        else n_pass++;
        send(32'h4000_0000, 1'b0);
        n_checks++;
        if (bus.resp_fault !== 1'b0 || bus.resp_paddr !== 24'h200000)
            $display("FAIL ro_read: f=%b pa=%h expected 0/200000", bus.resp_fault, bus.resp_paddr);
        else n_pass++;
        send(32'h8000_0004, 1'b0);
        n_checks++;
        if (bus.resp_fault !== 1'b1 || bus.resp_cause !== 2'b01)
            $display("FAIL seg_disabled: f=%b c=%b expected 1/01", bus.resp_fault, bus.resp_cause);
        else n_pass++;
        // Disabled outranks both limit and read-only violations.
        send(32'hC000_0100, 1'b1);
        n_checks++;
        if (bus.resp_cause !== 2'b01 || fault_cnt !== 8'(m_fcnt))
            $display("FAIL cause_priority: c=%b cnt=%0d expected 01/%0d", bus.resp_cause, fault_cnt, m_fcnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [PA_W-1:0] pa_a;
        drain();
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0123; bus.req_write = 1'b0; bus.resp_ready = 1'b0;
        model_accept(32'h0000_0123, 1'b0);
        pa_a = e_paddr;
        tick();
        bus.req_addr = 32'h0000_0456;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_paddr !== pa_a)
                $display("FAIL hold_%0d: rdy=%b v=%b pa=%h expected 0/1/%h", i, bus.req_ready, bus.resp_valid, bus.resp_paddr, pa_a);
            else n_pass++;
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", bus.req_ready);
        else n_pass++;
        model_accept(32'h0000_0456, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_paddr !== e_paddr)
            $display("FAIL release_data: v=%b pa=%h expected 1/%h", bus.resp_valid, bus.resp_paddr, e_paddr);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b0) $display("FAIL no_dup: v=%b expected 0", bus.resp_valid);
        else n_pass++;
    endtask

    task automatic test_cfg_same_cycle();
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0020; bus.req_write = 1'b0; bus.resp_ready = 1'b1;
        model_accept(32'h0000_0020, 1'b0);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_base = 24'h300000; cfg_limit = 30'h0000FFFF; cfg_en = 1'b1; cfg_ro = 1'b0;
        tick();
        cfg_we = 1'b0; bus.req_valid = 1'b0;
        m_base[0] = 24'h300000;
        n_checks++;
        if (bus.resp_paddr !== 24'h100020)
            $display("FAIL cfg_old_base: pa=%h expected 100020", bus.resp_paddr);
        else n_pass++;
        send(32'h0000_0020, 1'b0);
        n_checks++;
        if (bus.resp_paddr !== 24'h300020)
            $display("FAIL cfg_new_base: pa=%h expected 300020", bus.resp_paddr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_cfg(0, 24'hFFFFF0, 30'h000000FF, 1'b1, 1'b0);
        send(32'h0000_0020, 1'b1);
        n_checks++;
        if (bus.resp_paddr !== 24'h000010 || bus.resp_fault !== 1'b0)
            $display("FAIL wrap: pa=%h f=%b expected 000010/0", bus.resp_paddr, bus.resp_fault);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        drain();
        bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0004; bus.req_write = 1'b0; bus.resp_ready = 1'b0;
        model_accept(32'h8000_0004, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_fault !== 1'b1)
            $display("FAIL pending_fault: v=%b f=%b expected 1/1", bus.resp_valid, bus.resp_fault);
        else n_pass++;
        rst = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h0000_0000;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_base = 24'h555555; cfg_limit = '1; cfg_en = 1'b1;
        mode_we = 1'b1; mode_in = 1'b1;
        tick();
        rst = 1'b0; idle(); bus.resp_ready = 1'b0;
        model_reset();
        n_checks++;
        if (bus.resp_valid !== 1'b0 || fault_cnt !== '0 || fault_va !== '0 || bus.req_ready !== 1'b1)
            $display("FAIL mid_reset: v=%b cnt=%0d va=%h rdy=%b expected 0/0/0/1", bus.resp_valid, fault_cnt, fault_va, bus.req_ready);
        else n_pass++;
        send(32'hAB12_3456, 1'b0);
        n_checks++;
        if (bus.resp_paddr !== 24'h123456 || bus.resp_fault !== 1'b0)
            $display("FAIL mode_after_reset: pa=%h f=%b expected 123456/0", bus.resp_paddr, bus.resp_fault);
        else n_pass++;
        do_mode(1'b1);
        send(32'h0000_0010, 1'b0);
        n_checks++;
        if (bus.resp_cause !== 2'b01)
            $display("FAIL entry_cleared: c=%b expected 01", bus.resp_cause);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_cfg(2, '0, '0, 1'b0, 1'b0);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.resp_ready = 1'b1;
        for (int n = 0; n < 260; n++) begin
            bus.req_addr = 32'h8000_0000 | 32'(n);
            model_accept(bus.req_addr, 1'b0);
            tick();
            n_checks++;
            if (bus.resp_valid !== 1'b1 || fault_va !== m_fva || fault_cnt !== 8'(m_fcnt))
                $display("FAIL b2b_%0d: v=%b va=%h cnt=%0d expected 1/%h/%0d", n, bus.resp_valid, fault_va, fault_cnt, m_fva, m_fcnt);
            else n_pass++;
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (fault_cnt !== 8'hFF) $display("FAIL saturate: cnt=%0d expected 255", fault_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [PA_W-1:0] qp[$];
        logic            qf[$];
        logic [1:0]      qc[$];
        bit              exp_rdy;
        drain();
        for (int n = 0; n < 400; n++) begin
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_write  = 1'($urandom_range(0, 1));
            bus.req_addr   = {2'($urandom_range(0, 3)), 30'($urandom_range(0, 'h1FF))};
            if ($urandom_range(0, 7) == 0) bus.req_addr = $urandom();
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_idx   = 2'($urandom_range(0, 3));
            cfg_base  = 24'($urandom());
            cfg_limit = 30'($urandom_range(0, 'h1FF));
            cfg_en    = ($urandom_range(0, 3) != 0);
            cfg_ro    = 1'($urandom_range(0, 1));
            mode_we   = ($urandom_range(0, 15) == 0);
            mode_in   = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (qp.size() == 0) || bus.resp_ready;
            n_checks++;
            if (bus.req_ready !== exp_rdy)
                $display("FAIL rnd_ready_%0d: got %b expected %b", n, bus.req_ready, exp_rdy);
            else n_pass++;
            if (bus.resp_ready && qp.size() != 0) begin
                void'(qp.pop_front()); void'(qf.pop_front()); void'(qc.pop_front());
            end
            if (bus.req_valid && exp_rdy) begin
                model_accept(bus.req_addr, bus.req_write);
                qp.push_back(e_paddr); qf.push_back(e_fault); qc.push_back(e_cause);
            end
            tick();
            if (cfg_we) begin
                m_base[cfg_idx] = cfg_base; m_limit[cfg_idx] = cfg_limit;
                m_en[cfg_idx] = cfg_en; m_ro[cfg_idx] = cfg_ro;
            end
            if (mode_we) m_mode = mode_in;
            n_checks++;
            if (bus.resp_valid !== (qp.size() != 0) ||
                (qp.size() != 0 && {bus.resp_paddr, bus.resp_fault, bus.resp_cause} !== {qp[0], qf[0], qc[0]}) ||
                fault_cnt !== 8'(m_fcnt) || fault_va !== m_fva)
                $display("FAIL rnd_resp_%0d: v=%b pa=%h f=%b c=%b cnt=%0d va=%h; model n=%0d cnt=%0d va=%h",
                         n, bus.resp_valid, bus.resp_paddr, bus.resp_fault, bus.resp_cause,
                         fault_cnt, fault_va, qp.size(), m_fcnt, m_fva);
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_translate();
        test_protection();
        test_backpressure();
        test_cfg_same_cycle();
        test_wrap();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
